// File: rtl/synapse_accumulator_pkg.sv
// Shared definitions for the synapse averaging path.
// Holds the default info/divisor widths (shared with the downstream divider),
// the accumulator state enum and the saturation limit used when the
// ACC_SATURATE_EN build option is enabled.
package synapse_pkg;

  localparam int INFO_W_DEF = 14;
  localparam int DIV_W_DEF  = 13;

  typedef enum logic {
    ACCUM = 1'b0,
    REQ   = 1'b1
  } state_t;

  // Largest value representable in w bits (all ones).
  function automatic int unsigned sat_limit(input int unsigned w);
    return (32'd1 << w) - 32'd1;
  endfunction

  localparam int unsigned SAT_LIMIT = sat_limit(INFO_W_DEF);

endpackage

// File: rtl/synapse_accumulator_if.sv
// Request/response link between the synapse accumulator (master) and the
// averaging divider (slave).
//
// Handshake: the master raises valid with info/divisor and holds all three
// constant until it samples ready=1 on a rising edge. The slave may only
// raise ready while valid=1, and avg must be valid in the cycle ready=1.
// The transfer completes on that edge; ready seen while valid=0 is ignored.
interface synapse_accumulator_if
  import synapse_pkg::*;
#(
  parameter int INFO_W = INFO_W_DEF,
  parameter int DIV_W  = DIV_W_DEF
) ();

  logic [INFO_W-1:0] info;
  logic [DIV_W-1:0]  divisor;
  logic              valid;
  logic              ready;
  logic [INFO_W-1:0] avg;

  modport master (
    output info,
    output divisor,
    output valid,
    input  ready,
    input  avg
  );

  modport slave (
    input  info,
    input  divisor,
    input  valid,
    output ready,
    output avg
  );

endinterface

// File: rtl/synapse_accumulator_sat_adder.sv
// Accumulator adder: INFO_W running sum plus a zero-extended WEIGHT_W addend.
// carry reports a carry out of INFO_W. With ACC_SATURATE_EN defined the sum
// clamps at all-ones on carry; otherwise it wraps modulo 2^INFO_W.
module sat_adder
  import synapse_pkg::*;
#(
  parameter int INFO_W   = INFO_W_DEF,
  parameter int WEIGHT_W = 8
) (
  input  logic [INFO_W-1:0]   a,
  input  logic [WEIGHT_W-1:0] b,
  output logic [INFO_W-1:0]   sum,
  output logic                carry
);

  logic [INFO_W:0] full;

  // Widen by one bit so the carry out of INFO_W is visible.
  always_comb begin
    full  = {1'b0, a} + {{(INFO_W + 1 - WEIGHT_W){1'b0}}, b};
    carry = full[INFO_W];
  end

`ifdef ACC_SATURATE_EN
  localparam logic [INFO_W-1:0] LIMIT = INFO_W'(sat_limit(INFO_W));

  // Once the sum clamps, every further add carries again, so it stays clamped.
  always_comb begin
    sum = carry ? LIMIT : full[INFO_W-1:0];
  end
`else
  // Wrap modulo 2^INFO_W; the carry still reports the wrap.
  always_comb begin
    sum = full[INFO_W-1:0];
  end
`endif

endmodule

// File: rtl/synapse_accumulator.sv
// Synapse accumulator: sums weighted spike events over a window, then asks
// the averaging divider for sum/count and forwards the returned average as a
// one-cycle result pulse. Build option ACC_SATURATE_EN makes the sum clamp
// instead of wrap (handled inside sat_adder).
module synapse_accumulator
  import synapse_pkg::*;
#(
  parameter int WEIGHT_W = 8,
  parameter int INFO_W   = INFO_W_DEF,
  parameter int DIV_W    = DIV_W_DEF,
  parameter int WINDOW   = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                spike_valid,
  input  logic [WEIGHT_W-1:0] spike_weight,
  output logic                spike_ready,
  input  logic                flush,
  output logic [INFO_W-1:0]   result,
  output logic                result_valid,
  output logic                overflow,
  output state_t              dbg_state,
  synapse_accumulator_if.master div
);

  state_t            state_q;
  state_t            state_d;
  logic [INFO_W-1:0] sum_q;
  logic [DIV_W-1:0]  count_q;
  logic              overflow_q;
  logic [INFO_W-1:0] info_q;
  logic [DIV_W-1:0]  divisor_q;
  logic [INFO_W-1:0] result_q;
  logic              result_valid_q;

  logic [INFO_W-1:0] add_sum;
  logic              add_carry;
  logic [DIV_W-1:0]  count_inc;
  logic              accept;
  logic              window_full;
  logic              flush_req;
  logic              handshake;
  logic              enter_req;

  sat_adder #(
    .INFO_W   (INFO_W),
    .WEIGHT_W (WEIGHT_W)
  ) u_sat_adder (
    .a     (sum_q),
    .b     (spike_weight),
    .sum   (add_sum),
    .carry (add_carry)
  );

  // Window-close and handshake conditions; flush counts a spike landing this cycle.
  always_comb begin
    accept      = (state_q == ACCUM) && spike_valid;
    count_inc   = count_q + DIV_W'(1);
    window_full = accept && (count_inc == DIV_W'(WINDOW));
    flush_req   = (state_q == ACCUM) && flush && (accept || (count_q != '0));
    handshake   = (state_q == REQ) && div.ready;
  end

  // State register; reset drops valid immediately and discards a pending window.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ACCUM;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: close the window on WINDOW samples or a non-empty flush.
  always_comb begin
    state_d   = state_q;
    enter_req = 1'b0;
    case (state_q)
      ACCUM: begin
        if (window_full || flush_req) begin
          state_d   = REQ;
          enter_req = 1'b1;
        end
      end
      REQ: begin
        if (div.ready) begin
          state_d = ACCUM;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  // Accumulate, snapshot the request, and capture the returned average.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sum_q          <= '0;
      count_q        <= '0;
      overflow_q     <= 1'b0;
      info_q         <= '0;
      divisor_q      <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
    end else begin
      result_valid_q <= 1'b0;
      if (accept) begin
        sum_q   <= add_sum;
        count_q <= count_inc;
        if (add_carry) begin
          overflow_q <= 1'b1;
        end
      end
      // The request snapshot includes a spike accepted on the closing edge.
      if (enter_req) begin
        info_q    <= accept ? add_sum : sum_q;
        divisor_q <= accept ? count_inc : count_q;
      end
      if (handshake) begin
        result_q       <= div.avg;
        result_valid_q <= 1'b1;
        sum_q          <= '0;
        count_q        <= '0;
        overflow_q     <= 1'b0;
      end
    end
  end

  // Output drive: valid and spike_ready follow the state directly.
  always_comb begin
    div.valid    = (state_q == REQ);
    div.info     = info_q;
    div.divisor  = divisor_q;
    spike_ready  = (state_q == ACCUM);
    result       = result_q;
    result_valid = result_valid_q;
    overflow     = overflow_q;
    dbg_state    = state_q;
  end

endmodule

// File: tb/tb_synapse_accumulator.sv
// Directed bench for synapse_accumulator: table of windows plus hand-written
// sequences for back-pressure, empty/simultaneous flush, overflow and reset.
// Instance a uses WINDOW=16, instance b uses WINDOW=128 for the overflow case.
module tb_synapse_accumulator;
  import synapse_pkg::*;

  logic clk = 1'b0;
  logic reset;

  // Clock and reset
  always #5 clk = ~clk;

  logic        sv_a, flush_a, sr_a, rv_a, ovf_a;
  logic [7:0]  sw_a;
  logic [13:0] res_a;
  state_t      st_a;

  logic        sv_b, flush_b, sr_b, rv_b, ovf_b;
  logic [7:0]  sw_b;
  logic [13:0] res_b;
  state_t      st_b;

  synapse_accumulator_if #(.INFO_W(14), .DIV_W(13)) ifa ();
  synapse_accumulator_if #(.INFO_W(14), .DIV_W(13)) ifb ();

  synapse_accumulator #(.WEIGHT_W(8), .INFO_W(14), .DIV_W(13), .WINDOW(16)) dut_a (
    .clk          (clk),
    .reset        (reset),
    .spike_valid  (sv_a),
    .spike_weight (sw_a),
    .spike_ready  (sr_a),
    .flush        (flush_a),
    .result       (res_a),
    .result_valid (rv_a),
    .overflow     (ovf_a),
    .dbg_state    (st_a),
    .div          (ifa)
  );

  synapse_accumulator #(.WEIGHT_W(8), .INFO_W(14), .DIV_W(13), .WINDOW(128)) dut_b (
    .clk          (clk),
    .reset        (reset),
    .spike_valid  (sv_b),
    .spike_weight (sw_b),
    .spike_ready  (sr_b),
    .flush        (flush_b),
    .result       (res_b),
    .result_valid (rv_b),
    .overflow     (ovf_b),
    .dbg_state    (st_b),
    .div          (ifb)
  );

  // Scoreboard
  int n_vec = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endtask

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic finish_req_a(input logic [13:0] avg, input logic [13:0] exp_info, input string tag);
    logic [31:0] exp_res;
    exp_q.push_back({18'd0, avg});
    repeat (3) step();
    check({tag, " valid held"}, {31'd0, ifa.valid}, 32'd1);
    check({tag, " info held"}, {18'd0, ifa.info}, {18'd0, exp_info});
    ifa.ready = 1'b1;
    ifa.avg   = avg;
    step();
    ifa.ready = 1'b0;
    ifa.avg   = '0;
    exp_res = exp_q.pop_front();
    check({tag, " result_valid"}, {31'd0, rv_a}, 32'd1);
    check({tag, " result"}, {18'd0, res_a}, exp_res);
    check({tag, " valid dropped"}, {31'd0, ifa.valid}, 32'd0);
    check({tag, " spike_ready back"}, {31'd0, sr_a}, 32'd1);
    check({tag, " overflow cleared"}, {31'd0, ovf_a}, 32'd0);
    step();
    check({tag, " pulse one cycle"}, {31'd0, rv_a}, 32'd0);
    check({tag, " result held"}, {18'd0, res_a}, exp_res);
  endtask

  typedef struct {
    int          n;
    logic [7:0]  w;
    bit          use_flush;
    logic [13:0] avg;
    logic [13:0] exp_info;
    logic [12:0] exp_div;
  } vec_t;

  vec_t vecs[5];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [13:0] exp_ovf_info;

    vecs[0] = '{n: 3,  w: 8'd7,   use_flush: 1'b1, avg: 14'd7,   exp_info: 14'd21,   exp_div: 13'd3};
    vecs[1] = '{n: 16, w: 8'd5,   use_flush: 1'b0, avg: 14'd5,   exp_info: 14'd80,   exp_div: 13'd16};
    vecs[2] = '{n: 1,  w: 8'd200, use_flush: 1'b1, avg: 14'd200, exp_info: 14'd200,  exp_div: 13'd1};
    vecs[3] = '{n: 5,  w: 8'd100, use_flush: 1'b1, avg: 14'd100, exp_info: 14'd500,  exp_div: 13'd5};
    vecs[4] = '{n: 16, w: 8'd255, use_flush: 1'b0, avg: 14'd255, exp_info: 14'd4080, exp_div: 13'd16};

    sv_a = 0; sw_a = 0; flush_a = 0; ifa.ready = 0; ifa.avg = 0;
    sv_b = 0; sw_b = 0; flush_b = 0; ifb.ready = 0; ifb.avg = 0;
    reset = 1'b0;
    repeat (3) step();
    reset = 1'b1;
    step();

    // Reset state
    check("rst valid", {31'd0, ifa.valid}, 32'd0);
    check("rst result_valid", {31'd0, rv_a}, 32'd0);
    check("rst overflow", {31'd0, ovf_a}, 32'd0);
    check("rst info", {18'd0, ifa.info}, 32'd0);
    check("rst divisor", {19'd0, ifa.divisor}, 32'd0);
    check("rst result", {18'd0, res_a}, 32'd0);
    check("rst spike_ready", {31'd0, sr_a}, 32'd1);
    check("rst state", {31'd0, st_a}, {31'd0, ACCUM});
    check("rst state b", {31'd0, st_b}, {31'd0, ACCUM});

    // Basic window: 10+20+30+40 then flush
    foreach (vecs[k]) begin end
    for (int i = 0; i < 4; i++) begin
      sv_a = 1'b1;
      sw_a = 8'(10 * (i + 1));
      step();
    end
    sv_a = 1'b0;
    check("basic no early valid", {31'd0, ifa.valid}, 32'd0);
    flush_a = 1'b1;
    step();
    flush_a = 1'b0;
    check("basic valid latency", {31'd0, ifa.valid}, 32'd1);
    check("basic info", {18'd0, ifa.info}, 32'd100);
    check("basic divisor", {19'd0, ifa.divisor}, 32'd4);
    check("basic spike_ready low", {31'd0, sr_a}, 32'd0);
    finish_req_a(14'd25, 14'd100, "basic");

    // Table-driven windows (first one also shows the sum restarted at 0)
    for (int v = 0; v < 5; v++) begin
      for (int i = 0; i < vecs[v].n; i++) begin
        sv_a = 1'b1;
        sw_a = vecs[v].w;
        step();
      end
      sv_a = 1'b0;
      if (vecs[v].use_flush) begin
        flush_a = 1'b1;
        step();
        flush_a = 1'b0;
      end
      check($sformatf("vec%0d valid", v), {31'd0, ifa.valid}, 32'd1);
      check($sformatf("vec%0d info", v), {18'd0, ifa.info}, {18'd0, vecs[v].exp_info});
      check($sformatf("vec%0d divisor", v), {19'd0, ifa.divisor}, {19'd0, vecs[v].exp_div});
      finish_req_a(vecs[v].avg, vecs[v].exp_info, $sformatf("vec%0d", v));
    end

    // Auto window with a spike held during REQ
    for (int i = 0; i < 16; i++) begin
      sv_a = 1'b1;
      sw_a = 8'd5;
      step();
    end
    check("auto valid", {31'd0, ifa.valid}, 32'd1);
    check("auto info", {18'd0, ifa.info}, 32'd80);
    check("auto divisor", {19'd0, ifa.divisor}, 32'd16);
    repeat (3) begin
      step();
      check("auto backpressure", {31'd0, sr_a}, 32'd0);
    end
    ifa.ready = 1'b1;
    ifa.avg   = 14'd5;
    step();
    ifa.ready = 1'b0;
    check("auto result_valid", {31'd0, rv_a}, 32'd1);
    check("auto result", {18'd0, res_a}, 32'd5);
    check("auto ready again", {31'd0, sr_a}, 32'd1);
    step();
    sv_a = 1'b0;
    flush_a = 1'b1;
    step();
    flush_a = 1'b0;
    check("held spike info", {18'd0, ifa.info}, 32'd5);
    check("held spike divisor", {19'd0, ifa.divisor}, 32'd1);
    finish_req_a(14'd5, 14'd5, "held");

    // Empty flush is ignored
    flush_a = 1'b1;
    step();
    flush_a = 1'b0;
    check("empty flush valid", {31'd0, ifa.valid}, 32'd0);
    step();
    check("empty flush no result", {31'd0, rv_a}, 32'd0);
    check("empty flush valid later", {31'd0, ifa.valid}, 32'd0);

    // Flush together with a spike into an empty window
    sv_a = 1'b1; sw_a = 8'd27; flush_a = 1'b1;
    step();
    sv_a = 1'b0; flush_a = 1'b0;
    check("simul valid", {31'd0, ifa.valid}, 32'd1);
    check("simul info", {18'd0, ifa.info}, 32'd27);
    check("simul divisor", {19'd0, ifa.divisor}, 32'd1);
    finish_req_a(14'd27, 14'd27, "simul");

    // Overflow on the WINDOW=128 instance: 70 x 255 = 17850
`ifdef ACC_SATURATE_EN
    exp_ovf_info = 14'd16383;
`else
    exp_ovf_info = 14'd1466;
`endif
    for (int i = 0; i < 70; i++) begin
      sv_b = 1'b1;
      sw_b = 8'd255;
      step();
    end
    sv_b = 1'b0;
    check("ovf before flush", {31'd0, ovf_b}, 32'd1);
    flush_b = 1'b1;
    step();
    flush_b = 1'b0;
    check("ovf valid", {31'd0, ifb.valid}, 32'd1);
    check("ovf info", {18'd0, ifb.info}, {18'd0, exp_ovf_info});
    check("ovf divisor", {19'd0, ifb.divisor}, 32'd70);
    check("ovf flag", {31'd0, ovf_b}, 32'd1);
    step();
    ifb.ready = 1'b1;
    ifb.avg   = 14'd234;
    step();
    ifb.ready = 1'b0;
    check("ovf result_valid", {31'd0, rv_b}, 32'd1);
    check("ovf result", {18'd0, res_b}, 32'd234);
    check("ovf cleared", {31'd0, ovf_b}, 32'd0);
    check("ovf spike_ready", {31'd0, sr_b}, 32'd1);

    // Asynchronous reset while valid is high
    sv_a = 1'b1; sw_a = 8'd9; flush_a = 1'b1;
    step();
    sv_a = 1'b0; flush_a = 1'b0;
    check("mid-req valid up", {31'd0, ifa.valid}, 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check("mid-req async drop", {31'd0, ifa.valid}, 32'd0);
    check("mid-req info cleared", {18'd0, ifa.info}, 32'd0);
    step();
    step();
    reset = 1'b1;
    step();
    check("post-reset valid", {31'd0, ifa.valid}, 32'd0);
    check("post-reset spike_ready", {31'd0, sr_a}, 32'd1);
    sv_a = 1'b1; sw_a = 8'd4; flush_a = 1'b1;
    step();
    sv_a = 1'b0; flush_a = 1'b0;
    check("discarded window info", {18'd0, ifa.info}, 32'd4);
    check("discarded window divisor", {19'd0, ifa.divisor}, 32'd1);
    finish_req_a(14'd4, 14'd4, "after reset");

    // Final report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/synapse_accumulator.md
Name: synapse_accumulator

Overview:
- Initiator side of the synapse averaging handshake. Sums weighted spike events over a window and counts them.
- At window end, presents info (sum) and divisor (count) with valid to the downstream averaging divider, then waits for its ready.
- Captures the returned avg and emits it as a one-cycle result pulse toward the neuron stage.

Parameters:
- WEIGHT_W, 8, width of incoming spike weight
- INFO_W, 14, width of sum/info and avg
- DIV_W, 13, width of count/divisor
- WINDOW, 16, sample count that triggers an automatic request (1..2^DIV_W-1)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- spike_valid  in  1  spike event present
- spike_weight  in  WEIGHT_W  unsigned weight of the event
- spike_ready  out  1  block can accept a spike this cycle
- flush  in  1  end the window early
- info  out  INFO_W  accumulated sum presented to the divider
- divisor  out  DIV_W  sample count presented to the divider
- valid  out  1  request to the divider; info/divisor stable while high
- ready  in  1  divider response; avg is valid when ready=1
- avg  in  INFO_W  average returned by the divider
- result  out  INFO_W  captured average
- result_valid  out  1  one-cycle pulse; result is new
- overflow  out  1  sum exceeded INFO_W range in the current window

Behaviour:
- Reset (reset=0, asynchronous):
  - State=ACCUM; sum=0, count=0.
  - info=0, divisor=0, valid=0, result=0, result_valid=0, overflow=0.
  - spike_ready=1 from the first edge after reset deasserts.
- ACCUM state:
  - spike_ready=1.
  - A spike is accepted on a clk edge with spike_valid=1: sum += zero-extended spike_weight, count += 1.
  - Transition to REQ on the next edge when either:
    - the post-accept count equals WINDOW, or
    - flush=1 and the post-accept count > 0.
  - A spike accepted in the same cycle as flush is included in the window.
  - flush with count=0 and no spike this cycle is ignored: no request and no result.
- REQ state:
  - spike_ready=0; incoming spikes are back-pressured, not dropped.
  - valid=1; info=sum and divisor=count, both registered and held constant until the handshake completes.
  - flush is ignored.
  - On an edge with ready=1:
    - result <= avg; result_valid=1 for exactly that next cycle.
    - valid=0; sum, count and overflow are cleared.
    - Return to ACCUM; spike_ready=1 in that same cycle.
- Latency:
  - valid asserts 1 cycle after the triggering accept or flush.
  - result_valid asserts 1 cycle after ready is sampled high.
  - Minimum window-to-window turnaround is 2 cycles plus the divider latency.
- ready while valid=0: ignored.
- result holds its value between pulses.
- Arithmetic:
  - Sum wraps modulo 2^INFO_W unless ACC_SATURATE_EN is defined.
  - overflow is sticky within a window: set on any carry out of INFO_W.
  - count never exceeds WINDOW, so divisor is always nonzero when valid=1.
- Reset mid-REQ: valid drops immediately (asynchronous) and the pending window is discarded.

Optional Feature:
- Macro: ACC_SATURATE_EN.
- Defined: sum clamps at 2^INFO_W-1 (16383 at default) and overflow=1 once clamped.
- Undefined: sum wraps modulo 2^INFO_W; overflow still flags the wrap.

Decomposition:
- Shared package synapse_pkg holds:
  - INFO_W and DIV_W defaults, shared with the divider;
  - the state enum {ACCUM, REQ};
  - the saturation limit constant.
- One natural sub-module: sat_adder (INFO_W sum + WEIGHT_W addend, with carry/overflow out and ACC_SATURATE_EN handling).
- The FSM and handshake stay in the top module.

Test Plan:
- Reset check:
  - Stimulus: hold reset=0 for 3 cycles, then release.
  - Response: valid, result_valid, overflow, info and divisor all 0; spike_ready=1.
  - Stimulus: assert reset=0 while valid=1.
  - Response: valid drops without waiting for an edge.
- Basic window with flush:
  - Stimulus: weights 10, 20, 30, 40, then flush; divider model returns avg=25 with ready 3 cycles after valid.
  - Response: info=100, divisor=4, valid=1 stable until ready; result=25 with a single-cycle result_valid; next window starts from sum=0.
- Auto window:
  - Stimulus: WINDOW=16, 16 spikes of weight 5; hold spike_valid high during REQ.
  - Response: info=80, divisor=16; spike_ready=0 in REQ; the held spike is accepted first in the new window (count=1, sum=5).
- Empty and simultaneous flush:
  - Stimulus: flush with count=0.
  - Response: valid never asserts.
  - Stimulus: flush in the same cycle as a spike of weight 27 into an empty window.
  - Response: info=27, divisor=1.
- Overflow:
  - Stimulus: WINDOW=128, 70 spikes of weight 255, then flush.
  - Response with ACC_SATURATE_EN: info=16383, overflow=1.
  - Response without: info=1466 (17850 mod 16384), overflow=1.
  - In both cases overflow clears after result_valid.
